cnn_layer_accel_wht_cfg_streamer: RTL

Transmit side of the weight-table configuration interface. Accepts a valid/ready stream of 16-bit weight words from the host/DMA path and drives `job_accept`, `config_mode`, `wht_config_wren` and `wht_config_data` into the CE weight table. It emits exactly 9 weights per 3x3 kernel for kernels 0..`num_kernels`, pulsing `kernel_config_valid` at each kernel boundary and `done` at the end of the job.

---
 rtl/cnn_layer_accel_wht_cfg_streamer_pkg.sv | 16 +
 rtl/cnn_layer_accel_wht_cfg_cksum.sv | 30 +++
 rtl/cnn_layer_accel_wht_cfg_streamer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_wht_cfg_streamer_pkg.sv
// rtl/cnn_layer_accel_wht_cfg_streamer_pkg.sv - shared constants and state encoding for the weight-table streamer
package cnn_layer_accel_wht_cfg_streamer_pkg;

   localparam int KERNEL_3x3_COUNT_FULL_MINUS_1 = 8;
   localparam int MAX_BRAM_3x3_KERNELS          = 64;
   localparam int WEIGHT_WIDTH                  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_FINISH = 3'd4
   } wht_cfg_state_e;

endpackage

// File: rtl/cnn_layer_accel_wht_cfg_cksum.sv
// rtl/cnn_layer_accel_wht_cfg_cksum.sv - 16-bit modular sum of loaded weights and sticky compare against the trailing checksum word
`ifdef WHT_CFG_CHECKSUM_EN
module cnn_layer_accel_wht_cfg_cksum
   import cnn_layer_accel_wht_cfg_streamer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_i,
   input  logic                    acc_en_i,
   input  logic                    chk_en_i,
   input  logic [WEIGHT_WIDTH-1:0] data_i,
   output logic                    error_o
);
   logic [WEIGHT_WIDTH-1:0] sum_q;
   logic                    error_q;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         sum_q   <= '0;
         error_q <= 1'b0;
      end else begin
         if (acc_en_i) sum_q <= sum_q + data_i;
         if (chk_en_i && (data_i != sum_q)) error_q <= 1'b1;
      end
   end

   assign error_o = error_q;

endmodule
`endif

// File: rtl/cnn_layer_accel_wht_cfg_streamer.sv
// rtl/cnn_layer_accel_wht_cfg_streamer.sv - streams 9 weights per kernel into the CE weight table
// Optional trailing checksum word and cfg_error flag under WHT_CFG_CHECKSUM_EN.
module cnn_layer_accel_wht_cfg_streamer
   import cnn_layer_accel_wht_cfg_streamer_pkg::*;
#(
   parameter int C_CLG2_MAX_KERNELS   = $clog2(MAX_BRAM_3x3_KERNELS),
   parameter int C_WEIGHTS_PER_KERNEL = KERNEL_3x3_COUNT_FULL_MINUS_1 + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
   input  logic                          wht_in_valid,
   input  logic [WEIGHT_WIDTH-1:0]       wht_in_data,
   output logic                          wht_in_ready,
   output logic                          job_accept,
   output logic                          config_mode,
   output logic                          wht_config_wren,
   output logic [WEIGHT_WIDTH-1:0]       wht_config_data,
   output logic                          kernel_config_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_error
);
   localparam int             WCW       = $clog2(C_WEIGHTS_PER_KERNEL);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(C_WEIGHTS_PER_KERNEL - 1);

   wht_cfg_state_e                state_q;
   logic [WCW-1:0]                word_cnt_q;
   logic [C_CLG2_MAX_KERNELS-1:0] kern_cnt_q;
   logic [C_CLG2_MAX_KERNELS-1:0] num_kernels_q;
   logic                          job_accept_q;
   logic                          config_mode_q;
   logic                          wren_q;
   logic                          kcv_q;
   logic                          done_q;
   logic [WEIGHT_WIDTH-1:0]       data_q;
   logic                          hs;

   assign wht_in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign hs           = wht_in_valid && wht_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         word_cnt_q    <= '0;
         kern_cnt_q    <= '0;
         num_kernels_q <= '0;
         job_accept_q  <= 1'b0;
         config_mode_q <= 1'b0;
         wren_q        <= 1'b0;
         kcv_q         <= 1'b0;
         done_q        <= 1'b0;
         data_q        <= '0;
      end else begin
         job_accept_q <= 1'b0;
         wren_q       <= 1'b0;
         kcv_q        <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  num_kernels_q <= num_kernels;
                  word_cnt_q    <= '0;
                  kern_cnt_q    <= '0;
                  job_accept_q  <= 1'b1;
                  config_mode_q <= 1'b1;
                  state_q       <= ST_CLEAR;
               end
            end
            ST_CLEAR: state_q <= ST_LOAD;
            ST_LOAD: begin
               if (hs) begin
                  data_q <= wht_in_data;
                  wren_q <= 1'b1;
                  if (word_cnt_q == LAST_WORD) begin
                     word_cnt_q <= '0;
                     kcv_q      <= 1'b1;
                     // kern_cnt holds at the last kernel so it never passes num_kernels
                     if (kern_cnt_q == num_kernels_q) begin
`ifdef WHT_CFG_CHECKSUM_EN
                        state_q <= ST_CHECK;
`else
                        state_q <= ST_FINISH;
`endif
                     end else begin
                        kern_cnt_q <= kern_cnt_q + C_CLG2_MAX_KERNELS'(1);
                     end
                  end else begin
                     word_cnt_q <= word_cnt_q + WCW'(1);
                  end
               end
            end
            ST_CHECK: if (hs) state_q <= ST_FINISH;
            ST_FINISH: begin
               config_mode_q <= 1'b0;
               done_q        <= 1'b1;
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign job_accept          = job_accept_q;
   assign config_mode         = config_mode_q;
   assign wht_config_wren     = wren_q;
   assign wht_config_data     = data_q;
   assign kernel_config_valid = kcv_q;
   assign done                = done_q;
   assign busy                = (state_q != ST_IDLE) || done_q;

`ifdef WHT_CFG_CHECKSUM_EN
   cnn_layer_accel_wht_cfg_cksum u_cksum (
      .clk      (clk),
      .rst      (rst),
      .clear_i  ((state_q == ST_IDLE) && start),
      .acc_en_i (hs && (state_q == ST_LOAD)),
      .chk_en_i (hs && (state_q == ST_CHECK)),
      .data_i   (wht_in_data),
      .error_o  (cfg_error)
   );
`else
   assign cfg_error = 1'b0;
`endif

endmodule
